// File: rtl/dram_responder.sv
// dram_responder: DRAM-port memory model with fixed access latency, refresh stalls and a one-entry request buffer
module dram_responder #(
  parameter int ADDR_BITS = 12,
  parameter int DATA_BITS = 32,
  parameter int ACCESS_LATENCY = 3,
  parameter int REFRESH_PERIOD = 512,
  parameter int REFRESH_CYCLES = 8,
  localparam int BYTES = DATA_BITS / 8
) (
  input  logic                 clk,
  input  logic                 sync_reset,
  input  logic [ADDR_BITS-1:0] dram_mem_addr,
  input  logic                 dram_mem_read_en,
  input  logic                 dram_mem_write_en,
  input  logic [BYTES-1:0]     dram_mem_byte_enable,
  input  logic [DATA_BITS-1:0] dram_mem_write_data,
  output logic                 dram_ack,
  output logic [DATA_BITS-1:0] dram_mem_read_data,
  output logic                 busy,
  output logic                 overflow_err
);
  localparam int RW = REFRESH_PERIOD > 1 ? $clog2(REFRESH_PERIOD + 1) : 1;
  typedef enum logic [1:0] {IDLE, ACCESS, ACK, REFRESH} state_t;
  typedef struct packed {
    logic                 we;
    logic [ADDR_BITS-1:0] addr;
    logic [BYTES-1:0]     be;
    logic [DATA_BITS-1:0] wd;
  } req_t;
  state_t state;
  req_t cur, pend, in_req;
  logic pend_v, ref_due, req, take_new, drain, store, drop, mem_we;
  logic [3:0] cnt;
  logic [7:0] rcnt;
  logic [RW-1:0] ref_cnt;
  logic [DATA_BITS-1:0] mem [2**ADDR_BITS];
  assign req = dram_mem_read_en | dram_mem_write_en;
  assign in_req = '{we: dram_mem_write_en, addr: dram_mem_addr, be: dram_mem_byte_enable, wd: dram_mem_write_data};
  assign take_new = state == IDLE && !ref_due && !pend_v && req;
  assign drain = pend_v && ((state == IDLE && !ref_due) || (state == REFRESH && rcnt == '0));
  assign drop = req && pend_v && !drain;
  assign store = req && !take_new && !drop;
  assign mem_we = !sync_reset && state == ACCESS && cnt == '0 && cur.we;
  assign busy = state != IDLE || pend_v;
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      state <= IDLE;
      pend_v <= 1'b0;
      cnt <= '0;
      rcnt <= '0;
      ref_cnt <= RW'(REFRESH_PERIOD);
      ref_due <= 1'b0;
      dram_ack <= 1'b0;
      dram_mem_read_data <= '0;
      overflow_err <= 1'b0;
    end else begin
      dram_ack <= 1'b0;
      if (store) pend <= in_req;
      pend_v <= store | (pend_v & ~drain);
      overflow_err <= overflow_err | drop;
      case (state)
        IDLE:
          if (ref_due) begin
            state <= REFRESH;
            rcnt <= 8'(REFRESH_CYCLES - 1);
          end else if (pend_v || req) begin
            state <= ACCESS;
            cnt <= 4'(ACCESS_LATENCY - 1);
            cur <= pend_v ? pend : in_req;
          end
        ACCESS:
          if (cnt == '0) begin
            state <= ACK;
            dram_ack <= 1'b1;
            if (!cur.we) dram_mem_read_data <= mem[cur.addr];
          end else cnt <= cnt - 1'b1;
        ACK: state <= IDLE;
        REFRESH:
          if (rcnt == '0) begin
            ref_due <= 1'b0;
            state <= pend_v ? ACCESS : IDLE;
            cnt <= 4'(ACCESS_LATENCY - 1);
            cur <= pend;
          end else rcnt <= rcnt - 1'b1;
        default: state <= IDLE;
      endcase
      if (REFRESH_PERIOD != 0) begin
        ref_cnt <= ref_cnt == '0 ? RW'(REFRESH_PERIOD - 1) : ref_cnt - 1'b1;
        if (ref_cnt == '0) ref_due <= 1'b1;
      end
    end
  end
  always_ff @(posedge clk)
    if (mem_we)
      for (int i = 0; i < BYTES; i++)
        if (cur.be[i]) mem[cur.addr][8*i +: 8] <= cur.wd[8*i +: 8];
endmodule

// File: tb/tb_dram_responder.sv
// tb_dram_responder: scoreboard bench, dut0 without refresh (exact latency), dut1 with fast refresh
module tb_dram_responder;
  localparam int AB = 12;
  localparam int DB = 32;
  localparam int NB = DB / 8;
  localparam int LAT = 3;
  localparam int RP = 16;
  localparam int RC = 8;
  typedef struct {
    logic rd;
    logic [DB-1:0] data;
    int cyc;
  } exp_t;
  logic clk = 1'b0;
  logic [1:0] rst, re, we, ack, busy, ovf;
  logic [1:0][AB-1:0] addr;
  logic [1:0][NB-1:0] be;
  logic [1:0][DB-1:0] wd, rdata;
  logic [DB-1:0] mdl [2][2**AB];
  logic [DB-1:0] last_rd [2];
  exp_t q0 [$];
  exp_t q1 [$];
  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  dram_responder #(.ACCESS_LATENCY(LAT), .REFRESH_PERIOD(0), .REFRESH_CYCLES(RC)) u_dut0 (
    .clk(clk), .sync_reset(rst[0]), .dram_mem_addr(addr[0]), .dram_mem_read_en(re[0]),
    .dram_mem_write_en(we[0]), .dram_mem_byte_enable(be[0]), .dram_mem_write_data(wd[0]),
    .dram_ack(ack[0]), .dram_mem_read_data(rdata[0]), .busy(busy[0]), .overflow_err(ovf[0]));
  dram_responder #(.ACCESS_LATENCY(LAT), .REFRESH_PERIOD(RP), .REFRESH_CYCLES(RC)) u_dut1 (
    .clk(clk), .sync_reset(rst[1]), .dram_mem_addr(addr[1]), .dram_mem_read_en(re[1]),
    .dram_mem_write_en(we[1]), .dram_mem_byte_enable(be[1]), .dram_mem_write_data(wd[1]),
    .dram_ack(ack[1]), .dram_mem_read_data(rdata[1]), .busy(busy[1]), .overflow_err(ovf[1]));
  task automatic chk(input string name, input logic [DB-1:0] act, input logic [DB-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
    end
  endtask
  function automatic int qsize(input int k);
    return k == 0 ? q0.size() : q1.size();
  endfunction
  task automatic mon(input int k);
    exp_t e;
    if (ack[k] !== 1'b1) return;
    if (qsize(k) == 0) begin
      chk($sformatf("dut%0d_unexpected_ack", k), DB'(ack[k]), '0);
      return;
    end
    if (k == 0) e = q0.pop_front();
    else e = q1.pop_front();
    if (e.cyc >= 0) chk($sformatf("dut%0d_ack_cycle", k), DB'(cyc), DB'(e.cyc));
    if (e.rd) begin
      chk($sformatf("dut%0d_read_data", k), rdata[k], e.data);
      last_rd[k] = e.data;
    end else chk($sformatf("dut%0d_read_data_held_on_write", k), rdata[k], last_rd[k]);
  endtask
  always @(negedge clk) begin
    mon(0);
    mon(1);
  end
  task automatic issue(input int k, input logic r, input logic w, input logic [AB-1:0] a,
                       input logic [NB-1:0] b, input logic [DB-1:0] d, input bit track, input int lat);
    exp_t e;
    if (track) begin
      e.rd = !w;
      e.cyc = lat < 0 ? -1 : cyc + lat;
      if (w)
        for (int i = 0; i < NB; i++)
          if (b[i]) mdl[k][a][8*i +: 8] = d[8*i +: 8];
      e.data = mdl[k][a];
      if (k == 0) q0.push_back(e);
      else q1.push_back(e);
    end
    addr[k] = a;
    re[k] = r;
    we[k] = w;
    be[k] = b;
    wd[k] = d;
    @(posedge clk);
    #1;
    re[k] = 1'b0;
    we[k] = 1'b0;
  endtask
  task automatic wait_q(input int k, input int lim);
    int n;
    n = 0;
    while (qsize(k) >= lim && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (qsize(k) >= lim) begin
      chk($sformatf("dut%0d_ack_timeout_outstanding", k), DB'(qsize(k)), DB'(lim - 1));
      if (k == 0) q0.delete();
      else q1.delete();
    end
  endtask
  task automatic drain(input int k);
    wait_q(k, 1);
    @(posedge clk);
    #1;
  endtask
  task automatic reset_dut(input int k);
    rst[k] = 1'b1;
    @(posedge clk);
    #1;
    rst[k] = 1'b0;
    last_rd[k] = '0;
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: bench still running at time 1000000, required completion earlier");
    $fatal(1, "watchdog expired");
  end
  initial begin
    int sel, gap, lat;
    rst = '1;
    re = '0;
    we = '0;
    addr = '0;
    be = '0;
    wd = '0;
    last_rd[0] = '0;
    last_rd[1] = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = '0;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("dut%0d_reset_ack", k), DB'(ack[k]), '0);
      chk($sformatf("dut%0d_reset_read_data", k), rdata[k], '0);
      chk($sformatf("dut%0d_reset_busy", k), DB'(busy[k]), '0);
      chk($sformatf("dut%0d_reset_overflow", k), DB'(ovf[k]), '0);
    end
    issue(0, 1'b0, 1'b1, 12'h010, 4'hF, 32'hDEADBEEF, 1, LAT + 1);
    chk("tp1_busy_during_access", DB'(busy[0]), 1);
    drain(0);
    issue(0, 1'b1, 1'b0, 12'h010, 4'hF, 32'h0, 1, LAT + 1);
    drain(0);
    repeat (3) @(posedge clk);
    #1;
    chk("tp1_read_data_held", rdata[0], 32'hDEADBEEF);
    chk("tp1_idle_not_busy", DB'(busy[0]), 0);
    issue(0, 1'b0, 1'b1, 12'h020, 4'hF, 32'h11223344, 1, LAT + 1);
    drain(0);
    issue(0, 1'b0, 1'b1, 12'h020, 4'b0101, 32'hAABBCCDD, 1, LAT + 1);
    drain(0);
    issue(0, 1'b0, 1'b1, 12'h021, 4'h0, 32'hFFFFFFFF, 1, LAT + 1);
    drain(0);
    issue(0, 1'b1, 1'b0, 12'h020, 4'hF, 32'h0, 1, LAT + 1);
    drain(0);
    chk("tp2_merged_word", rdata[0], 32'h11BB33DD);
    issue(0, 1'b0, 1'b1, 12'h001, 4'hF, 32'hA, 1, LAT + 1);
    issue(0, 1'b1, 1'b0, 12'h001, 4'hF, 32'h0, 1, 2 * LAT + 2);
    issue(0, 1'b1, 1'b0, 12'h002, 4'hF, 32'h0, 0, -1);
    chk("tp3_overflow_set", DB'(ovf[0]), 1);
    drain(0);
    repeat (4) @(posedge clk);
    #1;
    chk("tp3_overflow_sticky", DB'(ovf[0]), 1);
    chk("tp3_second_read_data", rdata[0], 32'hA);
    issue(0, 1'b1, 1'b1, 12'h040, 4'hF, 32'h77, 1, LAT + 1);
    drain(0);
    issue(0, 1'b1, 1'b0, 12'h040, 4'hF, 32'h0, 1, LAT + 1);
    drain(0);
    chk("tp6_both_strobes_write", rdata[0], 32'h77);
    issue(0, 1'b0, 1'b1, 12'h030, 4'hF, 32'h12345678, 1, LAT + 1);
    drain(0);
    issue(0, 1'b0, 1'b1, 12'h030, 4'hF, 32'h55, 0, -1);
    reset_dut(0);
    chk("tp5_busy_after_reset", DB'(busy[0]), 0);
    chk("tp5_ack_after_reset", DB'(ack[0]), 0);
    chk("tp5_overflow_cleared", DB'(ovf[0]), 0);
    chk("tp5_read_data_cleared", rdata[0], '0);
    repeat (LAT + 3) @(posedge clk);
    #1;
    chk("tp5_still_idle", DB'(busy[0]), 0);
    issue(0, 1'b1, 1'b0, 12'h030, 4'hF, 32'h0, 1, LAT + 1);
    drain(0);
    chk("tp5_prewrite_value", rdata[0], 32'h12345678);
    issue(1, 1'b0, 1'b1, 12'h050, 4'hF, 32'hCAFEF00D, 1, -1);
    drain(1);
    reset_dut(1);
    repeat (RP + 1) @(posedge clk);
    #1;
    issue(1, 1'b1, 1'b0, 12'h050, 4'hF, 32'h0, 1, LAT + 1 + RC);
    drain(1);
    chk("tp4_read_through_refresh", rdata[1], 32'hCAFEF00D);
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 16; i++) begin
        wait_q(k, 1);
        issue(k, 1'b0, 1'b1, 12'h100 + 12'(i), 4'hF, $urandom, 1, -1);
      end
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 150; i++) begin
        gap = $urandom_range(0, 3);
        repeat (gap) begin
          @(posedge clk);
          #1;
        end
        wait_q(k, k == 0 ? 2 : 1);
        sel = $urandom_range(0, 5);
        lat = (k == 0 && qsize(0) == 0) ? LAT + 1 : -1;
        issue(k, sel <= 2 || sel == 5, sel >= 3, 12'h100 + 12'($urandom_range(0, 15)),
              4'($urandom), $urandom, 1, lat);
      end
    drain(0);
    drain(1);
    chk("dut0_no_drop_in_random", DB'(ovf[0]), 0);
    chk("dut1_no_drop_in_random", DB'(ovf[1]), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
